// File: rtl/icache_pkg.sv
// Shared types, constants and address-field width helpers for the multi-line instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // adr[14:12] value whose 4 KiB block is not backed by SDRAM
    localparam logic [2:0] EXCL_WIN = 3'b111;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag spans adr[14 : 2+OFF_W+IDX_W]
    function automatic int tag_w(input int words_per_line, input int lines);
        return 13 - $clog2(words_per_line) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Cache data store: LINES x WORDS_PER_LINE x 32, one synchronous write port for refill
// and one combinational read port for hits and refill responses.
module icache_line_ram
    import icache_pkg::*;
#(
    parameter int LINES          = 4,
    parameter int WORDS_PER_LINE = 8,
    localparam int IDX_W         = idx_w(LINES),
    localparam int OFF_W         = off_w(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [LINES*WORDS_PER_LINE];

    // NOTE: storage arrays carry no reset; the valid bits alone decide whether contents are used.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_idx, wr_off}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_idx, rd_off}];

endmodule

// File: rtl/icache_ml.sv
// Direct-mapped multi-line instruction cache on the Wishbone slave path with line refill
// from the BRAM stream. Optional hit/miss counters are enabled with ICACHE_PERF_CNT_EN.
module icache_ml
    import icache_pkg::*;
#(
    parameter int          LINES          = 4,
    parameter int          WORDS_PER_LINE = 8,
    parameter logic [15:0] BASE_HI        = 16'h3800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_cache_miss,
    output logic [31:0] refill_adr_o,
    input  logic [31:0] bram_data_in,
    input  logic        bram_in_valid,
    input  logic        flush_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(WORDS_PER_LINE, LINES);

    state_t state_q, state_d;

    logic [OFF_W-1:0] req_off, lat_off, word_cnt, rd_off;
    logic [IDX_W-1:0] req_idx, lat_idx, rd_idx;
    logic [TAG_W-1:0] req_tag, lat_tag;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [LINES-1:0] valid;
    logic [31:0]      rd_data;
    logic             req_ok, hit, hit_ack, start_fill, last_word, fill_we, flush_pend;
    logic             unused_adr_bits;

    assign req_off = wbs_adr_i[2 +: OFF_W];
    assign req_idx = wbs_adr_i[2+OFF_W +: IDX_W];
    assign req_tag = wbs_adr_i[14 -: TAG_W];
    assign unused_adr_bits = ^{wbs_adr_i[15], wbs_adr_i[1:0]};

    assign req_ok = wbs_stb_i & wbs_cyc_i & ~wbs_we_i
                  & (wbs_adr_i[31:16] == BASE_HI) & (wbs_adr_i[14:12] != EXCL_WIN);
    assign hit    = valid[req_idx] & (tag_mem[req_idx] == req_tag);
    assign fill_we = (state_q == ST_REFILL) & bram_in_valid;

    // During refill the read port serves the latched word for the response.
    assign rd_idx = (state_q == ST_REFILL) ? lat_idx : req_idx;
    assign rd_off = (state_q == ST_REFILL) ? lat_off : req_off;

    icache_line_ram #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (fill_we),
        .wr_idx  (lat_idx),
        .wr_off  (word_cnt),
        .wr_data (bram_data_in),
        .rd_idx  (rd_idx),
        .rd_off  (rd_off),
        .rd_data (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        hit_ack    = 1'b0;
        start_fill = 1'b0;
        last_word  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The request that was just acked is still on the bus; do not answer it twice.
                if (req_ok && !wbs_ack_o) begin
                    if (hit) begin
                        hit_ack = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_d    = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (bram_in_valid && (&word_cnt)) begin
                    last_word = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            wbs_cache_miss <= 1'b0;
            refill_adr_o   <= '0;
            word_cnt       <= '0;
            valid          <= '0;
            flush_pend     <= 1'b0;
            lat_idx        <= '0;
            lat_off        <= '0;
            lat_tag        <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            if (hit_ack) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= rd_data;
            end
            if (start_fill) begin
                lat_idx        <= req_idx;
                lat_off        <= req_off;
                lat_tag        <= req_tag;
                word_cnt       <= '0;
                flush_pend     <= 1'b0;
                wbs_cache_miss <= 1'b1;
                refill_adr_o   <= {BASE_HI, 1'b0, req_tag, req_idx, {(OFF_W+2){1'b0}}};
            end
            if (fill_we) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if ((state_q == ST_REFILL) && flush_i) begin
                flush_pend <= 1'b1;
            end
            if (last_word) begin
                wbs_cache_miss <= 1'b0;
                if (req_ok) begin
                    wbs_ack_o <= 1'b1;
                    // The last word is still on the stream, not yet in the RAM.
                    wbs_dat_o <= (&lat_off) ? bram_data_in : rd_data;
                end
                if (!flush_pend && !flush_i) begin
                    valid[lat_idx] <= 1'b1;
                end
            end
            // Placed last so a flush overrides a same-cycle validation.
            if (flush_i) begin
                valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (last_word) begin
            tag_mem[lat_idx] <= lat_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit_ack && (hit_cnt_o != '1)) begin
                hit_cnt_o <= hit_cnt_o + 1'b1;
            end
            if (start_fill && (miss_cnt_o != '1)) begin
                miss_cnt_o <= miss_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ml.sv
// Scoreboard bench for icache_ml: stimulus pushes expected ack data and refill addresses,
// a negedge monitor pops and compares them whenever the DUT presents an ack or raises a miss.
module tb_icache_ml;

    localparam int WPL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we_i = 1'b0;
    logic [31:0] adr = '0;
    logic        ack, miss;
    logic [31:0] dat, ref_adr;
    logic [31:0] bram_data = '0;
    logic        bram_valid = 1'b0;
    logic        flush = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_ml dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wbs_stb_i      (stb),
        .wbs_cyc_i      (cyc),
        .wbs_we_i       (we_i),
        .wbs_adr_i      (adr),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (dat),
        .wbs_cache_miss (miss),
        .refill_adr_o   (ref_adr),
        .bram_data_in   (bram_data),
        .bram_in_valid  (bram_valid),
        .flush_i        (flush)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    int ack_cnt = 0, miss_rise = 0, miss_cycles = 0;
    logic        miss_prev = 1'b0;
    logic [31:0] cur_ref = '0;
    logic [31:0] exp_dat_q[$];
    logic [31:0] exp_ref_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops expectations whenever the DUT acks or opens a refill.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack) begin
                ack_cnt++;
                if (exp_dat_q.size() == 0) begin
                    flag($sformatf("unexpected_ack data %h", dat));
                end else begin
                    check("ack_data", dat, exp_dat_q.pop_front());
                end
            end else if (dat !== 32'h0) begin
                check("dat_zero_without_ack", dat, 32'h0);
            end
            if (miss) begin
                miss_cycles++;
                if (!miss_prev) begin
                    miss_rise++;
                    if (exp_ref_q.size() == 0) begin
                        flag($sformatf("unexpected_miss refill_adr %h", ref_adr));
                    end else begin
                        cur_ref = exp_ref_q.pop_front();
                        check("refill_adr", ref_adr, cur_ref);
                    end
                end else if (ref_adr !== cur_ref) begin
                    check("refill_adr_stable", ref_adr, cur_ref);
                end
            end
            miss_prev = miss;
        end else begin
            miss_prev = 1'b0;
        end
    end

    task automatic start_req(input logic [31:0] a, input logic w);
        @(negedge clk);
        adr  = a;
        we_i = w;
        stb  = 1'b1;
        cyc  = 1'b1;
    endtask

    task automatic drop_req();
        stb  = 1'b0;
        cyc  = 1'b0;
        we_i = 1'b0;
    endtask

    // Waits for the ack, then releases the bus just after the edge that sampled it.
    task automatic await_ack(input string name, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) flag({name, " no ack within 40 cycles"});
        @(posedge clk);
        #1 drop_req();
    endtask

    // Arbiter/BRAM model: after miss is seen, streams one line starting at base.
    task automatic feed(input logic [31:0] base, input int gap_at, input int flush_at,
                        input int drop_at, input int rst_at);
        int  w = 0;
        bit  gap_done = 0;
        for (int i = 0; i < 10 && !miss; i++) @(negedge clk);
        if (!miss) begin
            flag("miss_never_raised");
            return;
        end
        while (w < WPL) begin
            @(negedge clk);
            flush = 1'b0;
            if (w == rst_at) begin
                rst_n      = 1'b0;
                bram_valid = 1'b0;
                drop_req();
                @(negedge clk);
                check("rst_mid_ack", {31'b0, ack}, 32'h0);
                check("rst_mid_dat", dat, 32'h0);
                check("rst_mid_miss", {31'b0, miss}, 32'h0);
                check("rst_mid_refill_adr", ref_adr, 32'h0);
                rst_n = 1'b1;
                return;
            end
            if (w == gap_at && !gap_done) begin
                bram_valid = 1'b0;
                gap_done   = 1;
            end else begin
                bram_valid = 1'b1;
                bram_data  = base + w;
                flush      = (w == flush_at);
                if (w == drop_at) drop_req();
                w++;
            end
        end
        @(posedge clk);
        #1;
        bram_valid = 1'b0;
        flush      = 1'b0;
    endtask

    // One complete miss: expected refill address and ack data are queued before stimulus.
    task automatic miss_fetch(input string name, input logic [31:0] a, input logic [31:0] exp_ref,
                              input logic [31:0] base, input int gap_at, input int flush_at,
                              input int exp_miss_cycles);
        int lat, mc0, mr0;
        mc0 = miss_cycles;
        mr0 = miss_rise;
        exp_ref_q.push_back(exp_ref);
        exp_dat_q.push_back(base + a[4:2]);
        start_req(a, 1'b0);
        feed(base, gap_at, flush_at, -1, -1);
        await_ack(name, lat);
        check({name, "_ack_latency"}, lat, 1);
        check({name, "_miss_count"}, miss_rise - mr0, 1);
        if (exp_miss_cycles > 0) check({name, "_miss_cycles"}, miss_cycles - mc0, exp_miss_cycles);
    endtask

    task automatic hit_fetch(input string name, input logic [31:0] a, input logic [31:0] exp_dat);
        int lat, mr0, ac0;
        mr0 = miss_rise;
        ac0 = ack_cnt;
        exp_dat_q.push_back(exp_dat);
        start_req(a, 1'b0);
        await_ack(name, lat);
        repeat (2) @(negedge clk);
        check({name, "_ack_latency"}, lat, 1);
        check({name, "_no_miss"}, miss_rise - mr0, 0);
        check({name, "_single_ack"}, ack_cnt - ac0, 1);
    endtask

    initial begin
        int ac0, mr0;

        repeat (3) @(negedge clk);
        check("reset_ack", {31'b0, ack}, 32'h0);
        check("reset_dat", dat, 32'h0);
        check("reset_miss", {31'b0, miss}, 32'h0);
        check("reset_refill_adr", ref_adr, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Cold fetch; arbiter answers one cycle after seeing miss, so miss stays up 9 cycles.
        miss_fetch("cold", 32'h3800_0104, 32'h3800_0100, 32'hA0, -1, -1, 9);
        hit_fetch("hit_last_word", 32'h3800_011C, 32'hA7);

        // Same index, new tag, with a one-cycle gap in the refill stream.
        miss_fetch("conflict", 32'h3800_0180, 32'h3800_0180, 32'hB0, 2, -1, 10);
        miss_fetch("refetch_evicted", 32'h3800_0104, 32'h3800_0100, 32'hC0, -1, -1, 9);

        // Excluded 4 KiB block, write, and a foreign window are all ignored.
        ac0 = ack_cnt;
        mr0 = miss_rise;
        start_req(32'h3800_7000, 1'b0);
        repeat (4) @(negedge clk);
        start_req(32'h3800_0100, 1'b1);
        repeat (4) @(negedge clk);
        start_req(32'h3801_0104, 1'b0);
        repeat (4) @(negedge clk);
        drop_req();
        repeat (2) @(negedge clk);
        check("ignored_no_ack", ack_cnt - ac0, 0);
        check("ignored_no_miss", miss_rise - mr0, 0);

        // Flush mid-refill: answer still delivered, line and the older index-0 line left invalid.
        miss_fetch("flush_mid", 32'h3800_0124, 32'h3800_0120, 32'hD0, -1, 3, 9);
        miss_fetch("after_flush_same", 32'h3800_0124, 32'h3800_0120, 32'hE0, -1, -1, 9);
        miss_fetch("after_flush_other", 32'h3800_0108, 32'h3800_0100, 32'hF0, -1, -1, 9);

        // Flush coinciding with the final refill word.
        miss_fetch("flush_last", 32'h3800_0144, 32'h3800_0140, 32'h50, -1, 7, 9);
        miss_fetch("after_flush_last", 32'h3800_0144, 32'h3800_0140, 32'h60, -1, -1, 9);

        // CPU abandons the request during refill: no ack, but the line becomes valid.
        ac0 = ack_cnt;
        exp_ref_q.push_back(32'h3800_0160);
        start_req(32'h3800_0164, 1'b0);
        feed(32'h70, -1, -1, 2, -1);
        repeat (3) @(negedge clk);
        check("dropped_no_ack", ack_cnt - ac0, 0);
        hit_fetch("hit_after_drop", 32'h3800_0168, 32'h72);

`ifdef ICACHE_PERF_CNT_EN
        check("perf_hits", hit_cnt, 32'd2);
        check("perf_misses", miss_cnt, 32'd9);
`endif

        // Reset while word 5 of a refill is due.
        exp_ref_q.push_back(32'h3800_0200);
        start_req(32'h3800_0204, 1'b0);
        feed(32'h80, -1, -1, -1, 5);
        repeat (2) @(negedge clk);
        miss_fetch("after_reset", 32'h3800_0204, 32'h3800_0200, 32'h90, -1, -1, 9);

        repeat (3) @(negedge clk);
        check("dat_queue_drained", exp_dat_q.size(), 32'd0);
        check("ref_queue_drained", exp_ref_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
